multi_wr_fifo: RTL

Nine-port-write, single-port-read buffer, the DUT-side endpoint of the testbench write/read interface. Each cycle it accepts up to nine 9-bit words from parallel write ports and packs them in ascending port order into one circular store. It drains one word per read request and asserts `freeze_clk` to stall the producer while free space is below one full write burst.

---
 rtl/multi_wr_fifo.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/multi_wr_fifo.sv
// multi_wr_fifo: nine-port-write, single-port-read circular buffer.
//   Each cycle up to nine 9-bit words from parallel write ports are packed,
//   in ascending port order, into consecutive slots of one circular store.
//   One word drains per read request. freeze_clk stalls the producer while
//   free space is below one full nine-word burst, so overflow cannot occur.
// Ports:
//   clk        - sole clock, rising edge
//   reset_n    - asynchronous active-low reset
//   wen[8:0]   - per-port write enable, bit k qualifies i_datak
//   i_data0..8 - 9-bit write data per port
//   ren        - read request
//   valid      - o_data holds a word popped on the previous edge
//   o_data     - registered read data
//   freeze_clk - producer must hold off writes while high
//   level      - registered occupancy

// Per-port write slot: the port's slot is wr_ptr plus the number of enabled
// ports below it, which packs enabled ports with no gaps.
module multi_wr_fifo_lane #(
  parameter int NUM_LANES = 9,
  parameter int AW        = 4
) (
  input  logic                 i_en,
  input  logic [NUM_LANES-1:0] i_below,  // enables of lower-numbered ports
  input  logic [AW-1:0]        i_wr_ptr,
  output logic                 o_we,
  output logic [AW-1:0]        o_addr
);
  localparam int CNT_W = $clog2(NUM_LANES + 1);

  logic [CNT_W-1:0] w_ofs;

  always_comb begin
    w_ofs = '0;
    for (int j = 0; j < NUM_LANES; j++)
      w_ofs = w_ofs + CNT_W'(i_below[j]);
  end

  // Address arithmetic wraps naturally modulo DEPTH (power of two)
  assign o_addr = i_wr_ptr + AW'(w_ofs);
  assign o_we   = i_en;
endmodule

module multi_wr_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [8:0]                 wen,
  input  logic [8:0]                 i_data0,
  input  logic [8:0]                 i_data1,
  input  logic [8:0]                 i_data2,
  input  logic [8:0]                 i_data3,
  input  logic [8:0]                 i_data4,
  input  logic [8:0]                 i_data5,
  input  logic [8:0]                 i_data6,
  input  logic [8:0]                 i_data7,
  input  logic [8:0]                 i_data8,
  input  logic                       ren,
  output logic                       valid,
  output logic [8:0]                 o_data,
  output logic                       freeze_clk,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int NUM_LANES = 9;
  localparam int VEC_W     = 9;
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;
  localparam int CNT_W     = $clog2(NUM_LANES + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] BURST_C = CW'(NUM_LANES);

  logic [VEC_W-1:0]                 r_mem [DEPTH];
  logic [AW-1:0]                    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]                    r_count;
  logic                             r_valid, r_freeze;
  logic [VEC_W-1:0]                 r_o_data;

  logic [NUM_LANES-1:0][VEC_W-1:0]  w_data;
  logic [NUM_LANES-1:0]             w_lane_we;
  logic [NUM_LANES-1:0][AW-1:0]     w_lane_addr;
  logic                             w_wr_ok, w_rd_fire;
  logic [CNT_W-1:0]                 w_n;
  logic [CW-1:0]                    w_count_nxt, w_free_nxt;

  assign w_data = {i_data8, i_data7, i_data6, i_data5, i_data4,
                   i_data3, i_data2, i_data1, i_data0};

  // Writes are dropped wholesale while the producer is frozen
  assign w_wr_ok   = !r_freeze;
  // Emptiness is judged before this cycle's writes: no fall-through
  assign w_rd_fire = ren && (r_count != '0);

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      multi_wr_fifo_lane #(.NUM_LANES(NUM_LANES), .AW(AW)) u_lane (
        .i_en     (wen[k] & w_wr_ok),
        .i_below  (wen & NUM_LANES'((1 << k) - 1)),
        .i_wr_ptr (r_wr_ptr),
        .o_we     (w_lane_we[k]),
        .o_addr   (w_lane_addr[k])
      );
    end
  endgenerate

  always_comb begin
    w_n = '0;
    for (int j = 0; j < NUM_LANES; j++)
      w_n = w_n + CNT_W'(w_lane_we[j]);
  end

  assign w_count_nxt = r_count + CW'(w_n) - CW'(w_rd_fire);
  assign w_free_nxt  = DEPTH_C - w_count_nxt;

  // Storage is not reset. Lane addresses are distinct by construction and
  // never alias a live entry, since at least nine slots are free on any
  // accepted write.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_LANES; j++)
      if (w_lane_we[j]) r_mem[w_lane_addr[j]] <= w_data[j];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_o_data <= '0;
      r_freeze <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_n);
      r_count  <= w_count_nxt;
      r_valid  <= w_rd_fire;
      r_freeze <= (w_free_nxt < BURST_C);
      if (w_rd_fire) begin
        r_o_data <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // level is the post-update count, identical to the count register
  assign level      = r_count;
  assign valid      = r_valid;
  assign o_data     = r_o_data;
  assign freeze_clk = r_freeze;
endmodule
